// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle RV32I control unit.
// Holds the FSM state enum, ALU_ctrl encodings, opcode constants,
// select encodings and the opcode -> instruction-class helper.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_LUI, CLS_JAL, CLS_JALR
  } op_class_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_BGE = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  function automatic op_class_t op_class(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_LUI:    return CLS_LUI;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/cache bus.
// master: control unit (drives ALU controls, selects, strobes, status).
// slave : datapath side (drives instr, eq, dmem_ready).
interface multicycle_control_unit_if #(
  parameter int Data_Width  = 32,
  parameter int Count_Width = 32
);
  logic [Data_Width-1:0]  instr;
  logic                   eq;
  logic                   dmem_ready;
  logic [3:0]             ALU_ctrl;
  logic                   alu_src_b;
  logic [2:0]             imm_src;
  logic [1:0]             result_src;
  logic [1:0]             pc_src;
  logic                   ir_write;
  logic                   pc_write;
  logic                   reg_write;
  logic                   dmem_req;
  logic                   mem_write;
  logic                   illegal;
  logic [Count_Width-1:0] instret;

  modport master (
    input  instr, eq, dmem_ready,
    output ALU_ctrl, alu_src_b, imm_src, result_src, pc_src, ir_write,
           pc_write, reg_write, dmem_req, mem_write, illegal, instret
  );

  modport slave (
    output instr, eq, dmem_ready,
    input  ALU_ctrl, alu_src_b, imm_src, result_src, pc_src, ir_write,
           pc_write, reg_write, dmem_req, mem_write, illegal, instret
  );
endinterface

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// Combinational ALU operation decoder.
// Inputs : cls (instruction class), funct3, f7b (funct7[5] for R-type,
//          imm[10] for I-type; both live in instr[30]).
// Outputs: alu_ctrl (4-bit ALU op), legal (class/funct combination supported).
module alu_op_decoder
  import core_ctrl_pkg::*;
(
  input  op_class_t  cls,
  input  logic [2:0] funct3,
  input  logic       f7b,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  logic is_r;
  assign is_r = (cls == CLS_R);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (cls)
      CLS_R, CLS_I: begin
        // For I-type the f7b bit is immediate data except on shifts.
        case (funct3)
          3'd0: alu_ctrl = (is_r && f7b) ? ALU_SUB : ALU_ADD;
          3'd1: begin alu_ctrl = ALU_SLL; legal = !f7b; end
          3'd2: begin alu_ctrl = ALU_SLT; legal = !is_r || !f7b; end
          3'd4: begin alu_ctrl = ALU_XOR; legal = !is_r || !f7b; end
          3'd5: alu_ctrl = f7b ? ALU_SRA : ALU_SRL;
          3'd6: begin alu_ctrl = ALU_OR;  legal = !is_r || !f7b; end
          3'd7: begin alu_ctrl = ALU_AND; legal = !is_r || !f7b; end
          default: legal = 1'b0; // sltu/sltiu not supported by the ALU
        endcase
      end
      CLS_LOAD, CLS_STORE: legal = (funct3 == 3'd2); // word access only
      CLS_JALR:            legal = (funct3 == 3'd0);
      CLS_BRANCH: begin
        case (funct3)
          3'd0, 3'd1: alu_ctrl = ALU_SUB;
          3'd4:       alu_ctrl = ALU_SLT;
          3'd5:       alu_ctrl = ALU_BGE;
          default:    legal = 1'b0;
        endcase
      end
      CLS_LUI, CLS_JAL: legal = 1'b1;
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT).
// Ports: clk, rst (async active-high), bus (master modport): instr, eq,
// dmem_ready in; ALU_ctrl, alu_src_b, imm_src, result_src, pc_src,
// ir_write, pc_write, reg_write, dmem_req, mem_write, illegal, instret out.
// State, IR copy, illegal and instret are registers; the strobes and
// selects are decoded from them so they line up with the current state.
module multicycle_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int Data_Width  = 32,
  parameter int Count_Width = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_unit_if.master bus
);

  state_t                 state;
  logic [Data_Width-1:0]  ir;
  logic                   illegal_q;
  logic [Count_Width-1:0] instret_q;

  op_class_t  cls;
  logic [2:0] funct3;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       taken;

  assign cls    = op_class(ir[6:0]);
  assign funct3 = ir[14:12];

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[Data_Width-1:31], ir[29:15], ir[11:7]};

  alu_op_decoder u_dec (
    .cls      (cls),
    .funct3   (funct3),
    .f7b      (ir[30]),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  // ALU compares as sub/slt/bge; only bne wants the inverted flag.
  assign taken = (funct3 == 3'd1) ? !bus.eq : bus.eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= bus.instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cls)
            CLS_BRANCH: begin
              state     <= S_FETCH;
              instret_q <= instret_q + Count_Width'(1);
            end
            CLS_LOAD, CLS_STORE: state <= S_MEM;
            default:             state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (cls == CLS_STORE) begin
              state     <= S_FETCH;
              instret_q <= instret_q + Count_Width'(1);
            end else begin
              state <= S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          state     <= S_FETCH;
          instret_q <= instret_q + Count_Width'(1);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  logic [3:0] alu_ctrl_d;
  logic       alu_src_b_d, ir_write_d, pc_write_d, reg_write_d;
  logic       dmem_req_d, mem_write_d;
  logic [2:0] imm_src_d;
  logic [1:0] result_src_d, pc_src_d;

  always_comb begin
    alu_ctrl_d   = ALU_ADD;
    alu_src_b_d  = 1'b0;
    imm_src_d    = IMM_I;
    result_src_d = RES_ALU;
    pc_src_d     = PC_PLUS4;
    ir_write_d   = 1'b0;
    pc_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    dmem_req_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (state)
      // Reset forces FETCH asynchronously; keep ir_write quiet while held.
      S_FETCH: ir_write_d = !rst;
      S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK: begin
        alu_ctrl_d  = dec_alu;
        alu_src_b_d = cls inside {CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR};
        case (cls)
          CLS_STORE:  imm_src_d = IMM_S;
          CLS_BRANCH: imm_src_d = IMM_B;
          CLS_LUI:    imm_src_d = IMM_U;
          CLS_JAL:    imm_src_d = IMM_J;
          default:    imm_src_d = IMM_I;
        endcase
        if (state == S_EXECUTE && cls == CLS_BRANCH) begin
          pc_write_d = 1'b1;
          pc_src_d   = taken ? PC_REL : PC_PLUS4;
        end
        if (state == S_MEM) begin
          dmem_req_d  = 1'b1;
          mem_write_d = (cls == CLS_STORE);
          // A store retires in the cycle the cache accepts it.
          pc_write_d  = (cls == CLS_STORE) && bus.dmem_ready;
        end
        if (state == S_WRITEBACK) begin
          reg_write_d = 1'b1;
          pc_write_d  = 1'b1;
          case (cls)
            CLS_LOAD:          result_src_d = RES_MEM;
            CLS_JAL, CLS_JALR: result_src_d = RES_PC4;
            CLS_LUI:           result_src_d = RES_IMM;
            default:           result_src_d = RES_ALU;
          endcase
          case (cls)
            CLS_JAL:  pc_src_d = PC_REL;
            CLS_JALR: pc_src_d = PC_ALU;
            default:  pc_src_d = PC_PLUS4;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.ALU_ctrl   = alu_ctrl_d;
  assign bus.alu_src_b  = alu_src_b_d;
  assign bus.imm_src    = imm_src_d;
  assign bus.result_src = result_src_d;
  assign bus.pc_src     = pc_src_d;
  assign bus.ir_write   = ir_write_d;
  assign bus.pc_write   = pc_write_d;
  assign bus.reg_write  = reg_write_d;
  assign bus.dmem_req   = dmem_req_d;
  assign bus.mem_write  = mem_write_d;
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;

endmodule
